// File: rtl/spi_frame_receiver_if.sv
// SPI pin bundle plus the downstream readback/strobe signals of the frame receiver.
interface spi_frame_receiver_if;
   logic        sclk;
   logic        cs_n;
   logic        mosi;
   logic        miso;
   logic [31:0] spi_data;
   logic        latch_data_sn;
   logic [15:0] memory_data;
   logic        data_valid_n;
   logic        rx_abort_n;

   modport slave (
      input  sclk, cs_n, mosi, memory_data, data_valid_n,
      output miso, spi_data, latch_data_sn, rx_abort_n
   );

   modport master (
      output sclk, cs_n, mosi, memory_data, data_valid_n,
      input  miso, spi_data, latch_data_sn, rx_abort_n
   );
endinterface

// File: rtl/spi_frame_receiver.sv
// Mode-0 SPI slave: oversamples the pins on the system clock, assembles 32-bit
// words, strobes latch_data_sn per word and shifts the readback word out on miso.
module spi_frame_receiver #(
   parameter int SYNC_STAGES = 2,
   parameter int LATCH_PULSE = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             enable_sn,
   spi_frame_receiver_if.slave bus
);

   logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
   logic        sclk_q, cs_q;
   logic        sclk_s, cs_s, mosi_s;
   logic        sclk_rise, sclk_fall, cs_rise, cs_fall;
   logic [5:0]  bit_cnt;
   logic [31:0] rx_sr, tx_sr, tx_hold, data_q;
   logic [31:0] rx_next;
   logic [3:0]  lp_cnt;
   logic        latch_q, abort_q;

   // Synchronizers reset to the idle bus state so release from reset never
   // fabricates an sclk edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sclk_sync <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         sclk_q    <= 1'b0;
         cs_q      <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
         sclk_q    <= sclk_s;
         cs_q      <= cs_s;
      end
   end

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_q;
   assign sclk_fall = ~sclk_s & sclk_q;
   assign cs_rise   = cs_s & ~cs_q;
   assign cs_fall   = ~cs_s & cs_q;
   assign rx_next   = {rx_sr[30:0], mosi_s};

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bit_cnt <= '0;
         rx_sr   <= '0;
         data_q  <= '0;
         lp_cnt  <= '0;
         latch_q <= 1'b1;
         abort_q <= 1'b1;
      end else if (enable_sn) begin
         bit_cnt <= '0;
         rx_sr   <= '0;
         lp_cnt  <= '0;
         latch_q <= 1'b1;
         abort_q <= 1'b1;
      end else begin
         abort_q <= 1'b1;
         if (lp_cnt != 4'd0) lp_cnt <= lp_cnt - 4'd1;
         else                latch_q <= 1'b1;
         if (cs_fall) begin
            bit_cnt <= '0;
         end else if (cs_rise) begin
            if (bit_cnt != 6'd0) abort_q <= 1'b0;
            bit_cnt <= '0;
         end else if (sclk_rise && !cs_s) begin
            rx_sr <= rx_next;
            if (bit_cnt == 6'd31) begin
               // Word complete: counter wraps so the next word in the same frame starts clean.
               bit_cnt <= '0;
               data_q  <= rx_next;
               latch_q <= 1'b0;
               lp_cnt  <= 4'(LATCH_PULSE - 1);
            end else begin
               bit_cnt <= bit_cnt + 6'd1;
            end
         end
      end
   end

   // Holding register decouples readback strobes from the frame in flight.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tx_hold <= '0;
         tx_sr   <= '0;
      end else begin
         if (!bus.data_valid_n) tx_hold <= {16'h0000, bus.memory_data};
         if (cs_fall)                   tx_sr <= tx_hold;
         else if (sclk_fall && !cs_s)   tx_sr <= {tx_sr[30:0], 1'b0};
      end
   end

   assign bus.miso          = ~cs_s & tx_sr[31];
   assign bus.spi_data      = data_q;
   assign bus.latch_data_sn = latch_q;
   assign bus.rx_abort_n    = abort_q;

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Directed bench with scoreboards for received words, abort strobes and miso readback.
module tb_spi_frame_receiver;
   logic clock = 1'b0;
   logic reset_n;
   logic enable_sn;
   spi_frame_receiver_if bus ();

   spi_frame_receiver #(.SYNC_STAGES(2), .LATCH_PULSE(4)) dut (
      .clock(clock), .reset_n(reset_n), .enable_sn(enable_sn), .bus(bus)
   );

   always #5 clock = ~clock;

   int n_chk = 0;
   int n_fail = 0;
   logic [31:0] exp_q[$];
   logic [31:0] abort_q[$];
   logic [63:0] miso_exp[$];
   logic [63:0] miso_got[$];
   logic [31:0] hold_m = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic strobe(input logic [15:0] v);
      @(negedge clock);
      bus.memory_data  = v;
      bus.data_valid_n = 1'b0;
      @(negedge clock);
      bus.data_valid_n = 1'b1;
      hold_m = {16'h0000, v};
   endtask

   // Sends the low nbits of data MSB first at clock/8; mode 0.
   task automatic frame(input logic [63:0] data, input int nbits, input bit release_cs,
                        input bit chk_miso, input logic [63:0] mexp);
      logic [63:0] cap;
      cap = '0;
      if (chk_miso) miso_exp.push_back(mexp);
      @(negedge clock);
      bus.cs_n = 1'b0;
      #40;
      for (int i = nbits - 1; i >= 0; i--) begin
         bus.mosi = data[i];
         #40;
         cap = {cap[62:0], bus.miso};
         bus.sclk = 1'b1;
         #40;
         bus.sclk = 1'b0;
      end
      #40;
      if (release_cs) begin
         bus.cs_n = 1'b1;
         #80;
      end
      if (chk_miso) miso_got.push_back(cap);
   endtask

   // Received-word and abort monitor.
   logic prev_latch = 1'b1, prev_abort = 1'b1;
   int lcnt = 0, acnt = 0;
   always @(negedge clock) begin
      if (!bus.latch_data_sn && prev_latch) begin
         if (exp_q.size() == 0) chk("unexpected_latch", {32'h0, bus.spi_data}, 64'hFFFF_FFFF_FFFF_FFFF);
         else chk("spi_data", {32'h0, bus.spi_data}, {32'h0, exp_q.pop_front()});
      end
      if (!bus.latch_data_sn) lcnt++;
      else if (!prev_latch) begin
         chk("latch_width", lcnt, 4);
         lcnt = 0;
      end
      if (!bus.rx_abort_n && prev_abort) begin
         if (abort_q.size() == 0) chk("unexpected_abort", {32'h0, bus.spi_data}, 64'hFFFF_FFFF_FFFF_FFFF);
         else chk("abort_spi_data", {32'h0, bus.spi_data}, {32'h0, abort_q.pop_front()});
      end
      if (!bus.rx_abort_n) acnt++;
      else if (!prev_abort) begin
         chk("abort_width", acnt, 1);
         acnt = 0;
      end
      prev_latch = bus.latch_data_sn;
      prev_abort = bus.rx_abort_n;
   end

   // miso monitor.
   always @(negedge clock) begin
      if (miso_got.size() > 0 && miso_exp.size() > 0)
         chk("miso", miso_got.pop_front(), miso_exp.pop_front());
   end

   initial begin
      reset_n = 1'b0;
      enable_sn = 1'b1;
      bus.sclk = 1'b0; bus.cs_n = 1'b1; bus.mosi = 1'b0;
      bus.memory_data = '0; bus.data_valid_n = 1'b1;
      repeat (4) @(negedge clock);
      chk("rst_spi_data", {32'h0, bus.spi_data}, 64'h0);
      chk("rst_latch", {63'h0, bus.latch_data_sn}, 64'h1);
      chk("rst_abort", {63'h0, bus.rx_abort_n}, 64'h1);
      chk("rst_miso", {63'h0, bus.miso}, 64'h0);
      reset_n = 1'b1;
      repeat (4) @(negedge clock);
      enable_sn = 1'b0;
      repeat (4) @(negedge clock);

      exp_q.push_back(32'hA5C3_0F01);
      frame({32'h0, 32'hA5C3_0F01}, 32, 1, 1, {32'h0, hold_m});

      exp_q.push_back(32'h0102_0304);
      exp_q.push_back(32'hFFFF_0000);
      frame({32'h0102_0304, 32'hFFFF_0000}, 64, 1, 1, {hold_m, 32'h0});
      chk("two_word_final", {32'h0, bus.spi_data}, {32'h0, 32'hFFFF_0000});

      abort_q.push_back(32'hFFFF_0000);
      frame({47'h0, 17'h1_5A5A}, 17, 1, 0, '0);
      chk("abort_keep", {32'h0, bus.spi_data}, {32'h0, 32'hFFFF_0000});

      strobe(16'hBEEF);
      exp_q.push_back(32'h1234_5678);
      frame({32'h0, 32'h1234_5678}, 32, 1, 1, {32'h0, 32'h0000_BEEF});

      exp_q.push_back(32'h89AB_CDEF);
      fork
         frame({32'h0, 32'h89AB_CDEF}, 32, 1, 1, {32'h0, 32'h0000_BEEF});
         begin
            repeat (100) @(posedge clock);
            strobe(16'hCAFE);
         end
      join

      exp_q.push_back(32'h0F0F_F0F0);
      frame({32'h0, 32'h0F0F_F0F0}, 32, 1, 1, {32'h0, 32'h0000_CAFE});

      @(negedge clock) enable_sn = 1'b1;
      frame({32'h0, 32'hDEAD_BEEF}, 32, 1, 0, '0);
      chk("disabled_keep", {32'h0, bus.spi_data}, {32'h0, 32'h0F0F_F0F0});
      @(negedge clock) enable_sn = 1'b0;
      repeat (4) @(negedge clock);
      exp_q.push_back(32'h2468_ACE0);
      frame({32'h0, 32'h2468_ACE0}, 32, 1, 1, {32'h0, 32'h0000_CAFE});

      frame({44'h0, 20'hF_0F0F}, 20, 0, 0, '0);
      @(negedge clock) reset_n = 1'b0;
      hold_m = '0;
      #1;
      chk("mid_rst_spi_data", {32'h0, bus.spi_data}, 64'h0);
      chk("mid_rst_latch", {63'h0, bus.latch_data_sn}, 64'h1);
      chk("mid_rst_abort", {63'h0, bus.rx_abort_n}, 64'h1);
      chk("mid_rst_miso", {63'h0, bus.miso}, 64'h0);
      bus.cs_n = 1'b1;
      bus.sclk = 1'b0;
      repeat (5) @(negedge clock);
      reset_n = 1'b1;
      repeat (5) @(negedge clock);
      exp_q.push_back(32'h1357_9BDF);
      frame({32'h0, 32'h1357_9BDF}, 32, 1, 1, {32'h0, hold_m});
      chk("post_rst_data", {32'h0, bus.spi_data}, {32'h0, 32'h1357_9BDF});

      repeat (20) @(negedge clock);
      chk("latch_q_empty", exp_q.size(), 0);
      chk("abort_q_empty", abort_q.size(), 0);
      chk("miso_q_empty", miso_exp.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
